// File: rtl/universal_shift_reg_pkg.sv
// rtl/universal_shift_reg_pkg.sv - mode codes, sequencer states and helpers for the universal shift register
package universal_shift_reg_pkg;

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_LOAD = 3'b001;
   localparam logic [2:0] MODE_SHL  = 3'b010;
   localparam logic [2:0] MODE_SHR  = 3'b011;
   localparam logic [2:0] MODE_ROTL = 3'b100;
   localparam logic [2:0] MODE_ROTR = 3'b101;
   localparam logic [2:0] MODE_ASR  = 3'b110;
   localparam logic [2:0] MODE_CLR  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Only shifts and rotates are worth repeating; hold/load/clear are idempotent.
   function automatic logic is_burst_mode(input logic [2:0] m);
      return (m >= MODE_SHL) && (m <= MODE_ASR);
   endfunction

endpackage

// File: rtl/universal_shift_reg_if.sv
// rtl/universal_shift_reg_if.sv - control/data bundle between a lab top level and the shift register
interface universal_shift_reg_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
);
   logic             en;
   logic [2:0]       mode;
   logic [WIDTH-1:0] d;
   logic             ser_in;
   logic             start;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] q;
   logic             ser_out_l;
   logic             ser_out_r;
   logic             busy;
   logic             done;

   modport master (
      output en, mode, d, ser_in, start, count,
      input  q, ser_out_l, ser_out_r, busy, done
   );

   modport slave (
      input  en, mode, d, ser_in, start, count,
      output q, ser_out_l, ser_out_r, busy, done
   );
endinterface

// File: rtl/universal_shift_reg_cell.sv
// rtl/universal_shift_reg_cell.sv - one register bit: next-value mux feeding a sync-reset enabled flop
module universal_shift_reg_cell
   import universal_shift_reg_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       rst_bit,
   input  logic [2:0] mode,
   input  logic       d_bit,
   input  logic       lo_bit,
   input  logic       hi_bit,
   output logic       q
);
   logic nxt;

   // lo_bit/hi_bit already carry the serial, rotate or sign source at the edges.
   always_comb begin
      nxt = 1'b0;
      case (mode)
         MODE_HOLD:                     nxt = q;
         MODE_LOAD:                     nxt = d_bit;
         MODE_SHL, MODE_ROTL:           nxt = lo_bit;
         MODE_SHR, MODE_ROTR, MODE_ASR: nxt = hi_bit;
         default:                       nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         q <= rst_bit;
      else if (en)
         q <= nxt;
   end
endmodule

// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - universal shift register with a burst sequencer repeating shifts/rotates
module universal_shift_reg
   import universal_shift_reg_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter int               CNT_W     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input logic                   clk,
   input logic                   reset,
   universal_shift_reg_if.slave  bus
);
   state_t           state;
   logic [CNT_W-1:0] remaining;
   logic [2:0]       lat_mode;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] q;
   logic [2:0]       cur_mode;
   logic             apply_en;

   assign cur_mode = (state == ST_RUN) ? lat_mode : bus.mode;
   assign apply_en = bus.en && (((state == ST_IDLE) && !bus.start) || (state == ST_RUN));

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic lo_bit;
      logic hi_bit;
      if (i == 0) begin : g_lsb
         assign lo_bit = (cur_mode == MODE_ROTL) ? q[WIDTH-1] : bus.ser_in;
      end else begin : g_lo
         assign lo_bit = q[i-1];
      end
      if (i == WIDTH-1) begin : g_msb
         assign hi_bit = (cur_mode == MODE_ROTR) ? q[0] :
                         (cur_mode == MODE_ASR)  ? q[WIDTH-1] : bus.ser_in;
      end else begin : g_hi
         assign hi_bit = q[i+1];
      end
      universal_shift_reg_cell u_cell (
         .clk     (clk),
         .reset   (reset),
         .en      (apply_en),
         .rst_bit (RESET_VAL[i]),
         .mode    (cur_mode),
         .d_bit   (bus.d[i]),
         .lo_bit  (lo_bit),
         .hi_bit  (hi_bit),
         .q       (q[i])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         remaining <= '0;
         lat_mode  <= MODE_HOLD;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (bus.en && bus.start) begin
                  lat_mode  <= bus.mode;
                  remaining <= bus.count;
                  if ((bus.count == '0) || !is_burst_mode(bus.mode)) begin
                     state  <= ST_DONE;
                     done_r <= 1'b1;
                  end else begin
                     state  <= ST_RUN;
                     busy_r <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (bus.en) begin
                  remaining <= remaining - CNT_W'(1);
                  if (remaining == CNT_W'(1)) begin
                     state  <= ST_DONE;
                     busy_r <= 1'b0;
                     done_r <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               // Held Start is deliberately ignored here so it re-arms one cycle later.
               state  <= ST_IDLE;
               done_r <= 1'b0;
            end
            default: begin
               state  <= ST_IDLE;
               busy_r <= 1'b0;
               done_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.q         = q;
   assign bus.ser_out_l = q[WIDTH-1];
   assign bus.ser_out_r = q[0];
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
endmodule

// File: tb/tb_universal_shift_reg.sv
// tb/tb_universal_shift_reg.sv - directed self-checking bench for universal_shift_reg
module tb_universal_shift_reg;
   import universal_shift_reg_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   total  = 0;
   int   passed = 0;
   int   busy_cycles;
   logic seen_done;

   universal_shift_reg_if #(.WIDTH(8), .CNT_W(4)) bus ();

   universal_shift_reg #(.WIDTH(8), .CNT_W(4), .RESET_VAL(8'h00)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      reset = 1'b1; bus.en = 1'b1; bus.mode = MODE_LOAD; bus.d = 8'hFF;
      bus.ser_in = 1'b0; bus.start = 1'b0; bus.count = 4'd0;
      tick(); tick();
      check("reset_q", 32'(bus.q), 32'h00);
      check("reset_busy", 32'(bus.busy), 32'h0);
      check("reset_done", 32'(bus.done), 32'h0);

      reset = 1'b0; bus.d = 8'hA5; tick();
      check("load_a5", 32'(bus.q), 32'hA5);
      bus.mode = MODE_ROTL; tick();
      check("rotl", 32'(bus.q), 32'h4B);
      bus.mode = MODE_ROTR; tick();
      check("rotr", 32'(bus.q), 32'hA5);
      bus.mode = MODE_ASR; tick();
      check("asr", 32'(bus.q), 32'hD2);
      check("ser_out_l", 32'(bus.ser_out_l), 32'h1);
      check("ser_out_r", 32'(bus.ser_out_r), 32'h0);
      bus.mode = MODE_HOLD; bus.en = 1'b0; bus.d = 8'h00; tick();
      check("en_low_hold", 32'(bus.q), 32'hD2);

      // SHL burst of 3 from 0x81 with serial 1
      bus.en = 1'b1; bus.mode = MODE_LOAD; bus.d = 8'h81; tick();
      bus.mode = MODE_SHL; bus.ser_in = 1'b1; bus.start = 1'b1; bus.count = 4'd3; tick();
      check("start_no_modify", 32'(bus.q), 32'h81);
      check("start_busy", 32'(bus.busy), 32'h1);
      bus.start = 1'b0; bus.mode = MODE_HOLD;
      busy_cycles = 1; seen_done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.busy) busy_cycles++;
         if (bus.done) begin seen_done = 1'b1; break; end
      end
      check("shl_done_seen", 32'(seen_done), 32'h1);
      check("shl_busy_cycles", 32'(busy_cycles), 32'd3);
      check("shl_q", 32'(bus.q), 32'h0F);
      check("shl_not_busy_at_done", 32'(bus.busy), 32'h0);
      tick();
      check("shl_done_one_cycle", 32'(bus.done), 32'h0);
      check("shl_q_after", 32'(bus.q), 32'h0F);

      // ROTL burst of 15 from 0x01, enable low every other cycle
      bus.mode = MODE_LOAD; bus.d = 8'h01; tick();
      bus.mode = MODE_ROTL; bus.start = 1'b1; bus.count = 4'd15; tick();
      bus.start = 1'b0; bus.mode = MODE_HOLD; seen_done = 1'b0;
      for (int i = 0; i < 100; i++) begin
         bus.en = (i % 2 == 0) ? 1'b0 : 1'b1;
         tick();
         if (bus.done) begin seen_done = 1'b1; break; end
      end
      check("rotl15_done_seen", 32'(seen_done), 32'h1);
      check("rotl15_q", 32'(bus.q), 32'h80);
      bus.en = 1'b1; tick();
      check("rotl15_done_cleared", 32'(bus.done), 32'h0);
      check("rotl15_q_held", 32'(bus.q), 32'h80);

      // Count = 0: no burst, single Done
      bus.mode = MODE_SHL; bus.start = 1'b1; bus.count = 4'd0; tick();
      check("cnt0_done", 32'(bus.done), 32'h1);
      check("cnt0_busy", 32'(bus.busy), 32'h0);
      check("cnt0_q", 32'(bus.q), 32'h80);
      bus.start = 1'b0; bus.mode = MODE_HOLD; tick();
      check("cnt0_done_clear", 32'(bus.done), 32'h0);

      // Non-burst mode (load) with Start
      bus.mode = MODE_LOAD; bus.d = 8'h33; bus.start = 1'b1; bus.count = 4'd5; tick();
      check("load_start_done", 32'(bus.done), 32'h1);
      check("load_start_busy", 32'(bus.busy), 32'h0);
      check("load_start_q", 32'(bus.q), 32'h80);
      bus.start = 1'b0; bus.mode = MODE_HOLD; tick();
      check("load_start_done_clear", 32'(bus.done), 32'h0);

      // Reset during second step of a Count=5 SHR burst
      bus.mode = MODE_SHR; bus.ser_in = 1'b0; bus.start = 1'b1; bus.count = 4'd5; tick();
      bus.start = 1'b0; bus.mode = MODE_HOLD; tick();
      check("shr_step1", 32'(bus.q), 32'h40);
      check("shr_busy", 32'(bus.busy), 32'h1);
      reset = 1'b1; tick();
      check("abort_q", 32'(bus.q), 32'h00);
      check("abort_busy", 32'(bus.busy), 32'h0);
      check("abort_done", 32'(bus.done), 32'h0);
      reset = 1'b0; tick();
      check("abort_no_late_done", 32'(bus.done), 32'h0);
      check("abort_idle_busy", 32'(bus.busy), 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
